// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit holding HI/LO; fixed data_width+2 cycle latency per op.
// MTHI/MTLO write in one cycle from idle; start is ignored while busy.
module mul_div_unit #(
  parameter int data_width = 32,
  parameter int op_width   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [op_width-1:0]   op,
  input  logic [data_width-1:0] operand1,
  input  logic [data_width-1:0] operand2,
  output logic [data_width-1:0] hi,
  output logic [data_width-1:0] lo,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = data_width;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [op_width-1:0] OP_MTHI = op_width'(4);
  localparam logic [op_width-1:0] OP_MTLO = op_width'(5);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mag_q, mag_d;
  logic [W-1:0]   op1_q, op1_d;
  logic [W-1:0]   op2_q, op2_d;
  logic           div_q, div_d;
  logic           uns_q, uns_d;
  logic           neg_q, neg_d;
  logic           negr_q, negr_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  // Sign handling of the captured operands, used during PREP.
  logic           sa, sb;
  logic [W-1:0]   ma, mb;
  assign sa = !uns_q && op1_q[W-1];
  assign sb = !uns_q && op2_q[W-1];
  assign ma = sa ? (~op1_q + 1'b1) : op1_q;
  assign mb = sb ? (~op2_q + 1'b1) : op2_q;

  // Multiply step: conditionally add multiplicand to the upper half, then shift right.
  logic [W:0]     mul_sum;
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_q} : {(W+1){1'b0}});

  // Restoring divide step on the left-shifted partial remainder.
  logic [W:0]     div_top;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  assign div_top  = acc_q[2*W-1:W-1];
  assign div_ge   = div_top >= {1'b0, mag_q};
  assign div_diff = div_top[W-1:0] - mag_q;

  logic [2*W-1:0] prod_signed;
  logic [W-1:0]   quo_signed, rem_signed;
  assign prod_signed = neg_q  ? (~acc_q + 1'b1) : acc_q;
  assign quo_signed  = neg_q  ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
  assign rem_signed  = negr_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    div_d   = div_q;
    uns_d   = uns_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op < OP_MTHI) begin
            state_d = S_PREP;
            op1_d   = operand1;
            op2_d   = operand2;
            div_d   = op[1];
            uns_d   = op[0];
          end else if (op == OP_MTHI) begin
            hi_d = operand1;
          end else if (op == OP_MTLO) begin
            lo_d = operand1;
          end
        end
      end
      S_PREP: begin
        cnt_d   = '0;
        state_d = S_ITER;
        neg_d   = sa ^ sb;
        negr_d  = sa;
        if (div_q) begin
          mag_d = mb;
          acc_d = {{W{1'b0}}, ma};
        end else begin
          mag_d = ma;
          acc_d = {{W{1'b0}}, mb};
        end
      end
      S_ITER: begin
        if (div_q) begin
          if (div_ge) acc_d = {div_diff, acc_q[W-2:0], 1'b1};
          else        acc_d = {acc_q[2*W-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      default: begin
        // Divide by zero still runs full latency; result is forced here.
        if (div_q && op2_q == '0) begin
          lo_d = {W{1'b1}};
          hi_d = op1_q;
        end else if (div_q) begin
          lo_d = quo_signed;
          hi_d = rem_signed;
        end else begin
          lo_d = prod_signed[W-1:0];
          hi_d = prod_signed[2*W-1:W];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      div_q   <= 1'b0;
      uns_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      div_q   <= div_d;
      uns_q   <= uns_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = state_q != S_IDLE;
  assign done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: fixed-latency arithmetic, MTHI/MTLO, busy protection, reset abort.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.data_width(32), .op_width(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand1(operand1), .operand2(operand2),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues the op, waits for done, checks latency and result.
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int k;
    start = 1'b1; op = o; operand1 = a; operand2 = b;
    @(negedge clk);
    start = 1'b0; op = 3'b110; operand1 = $urandom; operand2 = $urandom;
    check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    check({tag, "_done0"}, {31'd0, done}, 32'd0);
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, 32'd34);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; op = 3'b000; operand1 = '0; operand2 = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    start = 1'b1; op = 3'b100; operand1 = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    op = 3'b101; operand1 = 32'h9ABCDEF0;
    @(negedge clk);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    @(negedge clk);

    // Back-to-back: each run starts in the done cycle of the previous one.
    run("mult_neg",   3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run("multu_max",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run("mult_min",   3'b000, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000);
    run("div_neg",    3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu",       3'b011, 32'd100,      32'd7,        32'd2,        32'd14);
    run("div_ovf",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
    run("div_zero",   3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    run("divu_zero",  3'b011, 32'h0000002A, 32'd0,        32'h0000002A, 32'hFFFFFFFF);
    @(negedge clk);
    check("single_done", {31'd0, done}, 32'd0);

    // Busy protection: MTHI request mid-multiply must be ignored.
    start = 1'b1; op = 3'b000; operand1 = 32'd5; operand2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (9) begin
      @(negedge clk);
      ndone += int'(done);
    end
    start = 1'b1; op = 3'b100; operand1 = 32'hDEADBEEF; operand2 = 32'd99;
    @(negedge clk);
    ndone += int'(done);
    start = 1'b0;
    check("busy_ign_hi", hi, 32'h0000002A);
    check("busy_ign_busy", {31'd0, busy}, 32'd1);
    repeat (50) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("busy_ndone", ndone, 32'd1);
    check("busy_hi", hi, 32'd0);
    check("busy_lo", lo, 32'd30);

    // Reset mid-divide, with an MTHI request during the reset cycle.
    start = 1'b1; op = 3'b010; operand1 = 32'd100; operand2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 3'b100; operand1 = 32'hCAFEF00D;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("rstmid_nodone", ndone, 32'd0);
    check("rstmid_hi_after", hi, 32'd0);
    run("div_fresh", 3'b010, 32'd100, 32'd3, 32'd1, 32'd33);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
